// File: rtl/camera_ray_dispatcher.sv
// Primary camera ray generator: walks a frame in raster order and issues one direction vector per pixel,
// paced by a minimum issue gap and held off while no square-root unit reports idle.
module camera_ray_dispatcher #(
  parameter int                 H_RES     = 64,
  parameter int                 V_RES     = 48,
  parameter int                 ISSUE_GAP = 4,
  parameter logic signed [31:0] STEP_X    = 32'sd512,
  parameter logic signed [31:0] STEP_Y    = 32'sd512,
  parameter logic signed [31:0] Z_DIR     = -32'sd16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               frame_abort,
  input  logic [4:0]         sqrt_START,
  output logic               ray_VALID,
  output logic signed [31:0] DX,
  output logic signed [31:0] DY,
  output logic signed [31:0] DZ,
  output logic [15:0]        pix_x,
  output logic [15:0]        pix_y,
  output logic               frame_busy,
  output logic               frame_done
);

  // state | meaning
  // IDLE  | waiting for frame_start
  // ISSUE | walking pixels, one ray per permitted slot
  // DONE  | last ray issued, frame_done pulses on the next edge
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic signed [31:0] X0 = -($signed(32'(H_RES / 2)) * STEP_X);
  localparam logic signed [31:0] Y0 = $signed(32'(V_RES / 2)) * STEP_Y;
  localparam logic [15:0] PX_LAST = 16'(H_RES - 1);
  localparam logic [15:0] PY_LAST = 16'(V_RES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);

  state_t             state_q, state_d;
  logic [15:0]        px_q, px_d, py_q, py_d;
  logic signed [31:0] x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic               valid_q, valid_d, done_q, done_d;
  logic signed [31:0] dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic [15:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic               issue_ok;

  assign issue_ok = (gap_cnt_q == '0) && (|sqrt_START);

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    x_acc_d   = x_acc_q;
    y_acc_d   = y_acc_q;
    gap_cnt_d = gap_cnt_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    dx_d      = dx_q;
    dy_d      = dy_q;
    dz_d      = dz_q;
    pix_x_d   = pix_x_q;
    pix_y_d   = pix_y_q;
    case (state_q)
      IDLE: begin
        if (frame_start && !frame_abort) begin
          state_d   = ISSUE;
          px_d      = '0;
          py_d      = '0;
          x_acc_d   = X0;
          y_acc_d   = Y0;
          gap_cnt_d = '0;
        end
      end
      ISSUE: begin
        if (frame_abort) begin
          state_d = IDLE;
        end else if (issue_ok) begin
          valid_d   = 1'b1;
          dx_d      = x_acc_q;
          dy_d      = y_acc_q;
          dz_d      = Z_DIR;
          pix_x_d   = px_q;
          pix_y_d   = py_q;
          gap_cnt_d = GAP_LOAD;
          if (px_q < PX_LAST) begin
            px_d    = px_q + 16'd1;
            x_acc_d = x_acc_q + STEP_X;
          end else begin
            px_d    = '0;
            x_acc_d = X0;
            py_d    = py_q + 16'd1;
            y_acc_d = y_acc_q - STEP_Y;
          end
          if (px_q == PX_LAST && py_q == PY_LAST) state_d = DONE;
        end else if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = !frame_abort;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      px_q      <= '0;
      py_q      <= '0;
      x_acc_q   <= '0;
      y_acc_q   <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      x_acc_q   <= x_acc_d;
      y_acc_q   <= y_acc_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      dz_q      <= dz_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
    end
  end

  assign ray_VALID  = valid_q;
  assign DX         = dx_q;
  assign DY         = dy_q;
  assign DZ         = dz_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_busy = (state_q == ISSUE) || (state_q == DONE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_camera_ray_dispatcher.sv
// Directed bench: a 4x2 frame on two dispatchers, one back-to-back (gap 1), one paced (gap 4).
module tb_camera_ray_dispatcher;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               start_a = 1'b0, abort_a = 1'b0;
  logic [4:0]         sqrt_a = 5'h1F;
  logic               rv_a, busy_a, done_a;
  logic signed [31:0] dx_a, dy_a, dz_a;
  logic [15:0]        px_a, py_a;

  logic               start_b = 1'b0, abort_b = 1'b0;
  logic [4:0]         sqrt_b = 5'h10;
  logic               rv_b, busy_b, done_b;
  logic signed [31:0] dx_b, dy_b, dz_b;
  logic [15:0]        px_b, py_b;

  camera_ray_dispatcher #(.H_RES(4), .V_RES(2), .ISSUE_GAP(1)) u_dut_a (
    .clk(clk), .rst(rst), .frame_start(start_a), .frame_abort(abort_a), .sqrt_START(sqrt_a),
    .ray_VALID(rv_a), .DX(dx_a), .DY(dy_a), .DZ(dz_a), .pix_x(px_a), .pix_y(py_a),
    .frame_busy(busy_a), .frame_done(done_a)
  );

  camera_ray_dispatcher #(.H_RES(4), .V_RES(2), .ISSUE_GAP(4)) u_dut_b (
    .clk(clk), .rst(rst), .frame_start(start_b), .frame_abort(abort_b), .sqrt_START(sqrt_b),
    .ray_VALID(rv_b), .DX(dx_b), .DY(dy_b), .DZ(dz_b), .pix_x(px_b), .pix_y(py_b),
    .frame_busy(busy_b), .frame_done(done_b)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Hand-computed 4x2 directions: X0 = -2*512, Y0 = 1*512
  longint exp_dx [4] = '{-1024, -512, 0, 512};
  longint exp_dy [2] = '{512, 0};

  task automatic check(input string tag, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Waits for the next ray_VALID on dispatcher B; n = negedges waited.
  task automatic wait_pulse_b(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rv_b && n < 40);
    if (!rv_b) check("pulse_timeout", longint'(rv_b), 1);
  endtask

  task automatic start_frame_b();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
  endtask

  initial begin
    int n, skip, cnt;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, skip, cnt;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", rv_a, 0);
    check("rst_dx", dx_a, 0);
    check("rst_dz", dz_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pix", {px_b, py_b}, 0);
    rst = 1'b1;

    // A: back-to-back frame with gap 1
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("a_busy_start", busy_a, 1);
    check("a_no_pulse_yet", rv_a, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("a_valid%0d", i), rv_a, 1);
      check($sformatf("a_dx%0d", i), dx_a, exp_dx[i % 4]);
      check($sformatf("a_dy%0d", i), dy_a, exp_dy[i / 4]);
      check($sformatf("a_dz%0d", i), dz_a, -16384);
      check($sformatf("a_px%0d", i), px_a, i % 4);
      check($sformatf("a_py%0d", i), py_a, i / 4);
      check($sformatf("a_done_early%0d", i), done_a, 0);
    end
    @(negedge clk);
    check("a_done", done_a, 1);
    check("a_valid_after", rv_a, 0);
    check("a_busy_after", busy_a, 0);
    @(negedge clk);
    check("a_done_one_cycle", done_a, 0);
    check("a_dx_hold", dx_a, 512);
    check("a_dy_hold", dy_a, 0);
    check("a_px_hold", px_a, 3);

    // B frame 1: gap 4, stray frame_start mid-frame
    start_frame_b();
    skip = 0;
    for (int i = 0; i < 8; i++) begin
      wait_pulse_b(n);
      check($sformatf("b_spacing%0d", i), n, (i == 0) ? 1 : 4 - skip);
      skip = 0;
      check($sformatf("b_px%0d", i), px_b, i % 4);
      check($sformatf("b_py%0d", i), py_b, i / 4);
      check($sformatf("b_dx%0d", i), dx_b, exp_dx[i % 4]);
      check($sformatf("b_dy%0d", i), dy_b, exp_dy[i / 4]);
      if (i == 2) begin
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b_no_pulse_stray_start", rv_b, 0);
        skip = 1;
      end
    end
    @(negedge clk);
    check("b_done", done_b, 1);
    check("b_busy_after", busy_b, 0);

    // B frame 2: sqrt_START stall after second pulse
    sqrt_b = 5'h01;
    start_frame_b();
    wait_pulse_b(n);
    wait_pulse_b(n);
    check("stall_pre_px", px_b, 1);
    sqrt_b = 5'h00;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv_b) cnt++;
    end
    check("stall_no_pulses", cnt, 0);
    check("stall_busy", busy_b, 1);
    sqrt_b = 5'h04;
    wait_pulse_b(n);
    check("resume_latency", n, 1);
    check("resume_px", px_b, 2);
    check("resume_py", py_b, 0);
    check("resume_dx", dx_b, 0);
    abort_b = 1'b1;
    @(negedge clk); abort_b = 1'b0;
    check("abort2_busy", busy_b, 0);

    // B frame 3: abort on the cycle of the third pulse
    start_frame_b();
    wait_pulse_b(n);
    wait_pulse_b(n);
    repeat (3) @(negedge clk);
    check("pre_abort_no_pulse", rv_b, 0);
    abort_b = 1'b1;
    @(negedge clk); abort_b = 1'b0;
    check("abort_suppress", rv_b, 0);
    check("abort_busy", busy_b, 0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv_b || done_b) cnt++;
    end
    check("abort_quiet", cnt, 0);
    check("abort_px_hold", px_b, 1);

    // B frame 4: restart from (0,0), then reset mid-frame
    start_frame_b();
    wait_pulse_b(n);
    check("restart_latency", n, 1);
    check("restart_px", px_b, 0);
    check("restart_py", py_b, 0);
    check("restart_dx", dx_b, -1024);
    rst = 1'b0;
    #1;
    check("midrst_valid", rv_b, 0);
    check("midrst_dx", dx_b, 0);
    check("midrst_dy", dy_b, 0);
    check("midrst_dz", dz_b, 0);
    check("midrst_pix", {px_b, py_b}, 0);
    check("midrst_busy", busy_b, 0);
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv_b || busy_b) cnt++;
    end
    check("midrst_dropped", cnt, 0);

    // start and abort together in IDLE
    @(negedge clk); start_b = 1'b1; abort_b = 1'b1;
    @(negedge clk); start_b = 1'b0; abort_b = 1'b0;
    check("sa_busy", busy_b, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv_b) cnt++;
    end
    check("sa_no_pulse", cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
